// File: rtl/adc_collector.sv
// adc_collector: pairs left/right ADC samples from two Avalon-ST sinks, mixes
// them to mono and writes them into a circular window buffer. It pulses go_out
// with the quarter index each time a quarter of the buffer has been filled.
module adc_collector #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int MONO_MIX = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] left_in_data,
    input  logic              left_in_valid,
    output logic              left_in_ready,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic              right_in_valid,
    output logic              right_in_ready,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              buf_wren,
    input  logic              window_busy,
    output logic              go_out,
    output logic [1:0]        window_start,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t             state, state_nxt;
    logic               have_l, have_r;
    logic [DATA_W-1:0]  l_q, r_q;
    logic [ADDR_W-1:0]  wr_ptr;
    logic               l_xfer, r_xfer;
    logic               quarter_hit;
    logic [DATA_W-1:0]  mix;

    assign l_xfer = left_in_valid && left_in_ready;
    assign r_xfer = right_in_valid && right_in_ready;

    // Mono mix: sign-extend both channels, add and halve. The one extra bit
    // means the sum cannot overflow; truncation (no rounding) is intended.
    generate
        if (MONO_MIX != 0) begin : g_mix
            assign mix = DATA_W'(($signed({l_q[DATA_W-1], l_q}) +
                                  $signed({r_q[DATA_W-1], r_q})) >>> 1);
        end else begin : g_left
            assign mix = l_q;
        end
    endgenerate

    assign buf_wr_addr = wr_ptr;
    assign buf_wr_data = mix;

    // The write that completes a quarter is the one whose low address bits are all ones.
    assign quarter_hit = buf_wren && (&wr_ptr[ADDR_W-3:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a started pair always completes; enable only matters at pair boundaries.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = COLLECT;
            COLLECT: if ((have_l || l_xfer) && (have_r || r_xfer)) state_nxt = WRITE;
            WRITE:   state_nxt = enable ? COLLECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: a channel's ready stays low once its sample is held, which stalls an early source.
    always_comb begin
        left_in_ready  = 1'b0;
        right_in_ready = 1'b0;
        buf_wren       = 1'b0;
        case (state)
            COLLECT: begin
                left_in_ready  = !have_l;
                right_in_ready = !have_r;
            end
            WRITE:   buf_wren = 1'b1;
            default: ;
        endcase
    end

    // Sample holding and the write pointer; data is captured only on the transfer cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            have_l <= 1'b0;
            have_r <= 1'b0;
            l_q    <= '0;
            r_q    <= '0;
            wr_ptr <= '0;
        end else if (state == WRITE) begin
            have_l <= 1'b0;
            have_r <= 1'b0;
            wr_ptr <= wr_ptr + ADDR_W'(1);
        end else begin
            if (l_xfer) begin
                have_l <= 1'b1;
                l_q    <= left_in_data;
            end
            if (r_xfer) begin
                have_r <= 1'b1;
                r_q    <= right_in_data;
            end
        end
    end

    // Quarter signalling one cycle after the write; overrun is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            go_out       <= 1'b0;
            window_start <= 2'd0;
            overrun      <= 1'b0;
        end else begin
            go_out <= quarter_hit;
            if (quarter_hit) window_start <= wr_ptr[ADDR_W-1:ADDR_W-2];
            if (quarter_hit && window_busy) overrun <= 1'b1;
        end
    end

endmodule
